// File: rtl/mmio_parallel_port_pkg.sv
// Shared definitions for the memory-mapped parallel port: default parameters,
// register-window offsets and the address-offset decoder.
package mmio_parallel_port_pkg;

  localparam int PIO_DATA_W    = 8;
  localparam int PIO_ADDR_W    = 8;
  localparam int PIO_N_OUT     = 4;
  localparam int PIO_N_IN      = 4;
  localparam int PIO_BASE_ADDR = 'hF0;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_OUT,
    REG_IN,
    REG_STATUS,
    REG_MASK
  } reg_kind_e;

  function automatic int pio_ofs_out0();
    return 0;
  endfunction

  function automatic int pio_ofs_in0(input int n_out);
    return n_out;
  endfunction

  function automatic int pio_ofs_status(input int n_out, input int n_in);
    return n_out + n_in;
  endfunction

  function automatic int pio_ofs_mask(input int n_out, input int n_in);
    return n_out + n_in + 1;
  endfunction

  function automatic int pio_win_size(input int n_out, input int n_in);
    return n_out + n_in + 2;
  endfunction

  // Classifies a window offset; anything past MASK is outside the window.
  function automatic reg_kind_e pio_decode(input int off, input int n_out, input int n_in);
    if (off < pio_ofs_in0(n_out))                 return REG_OUT;
    else if (off < pio_ofs_status(n_out, n_in))   return REG_IN;
    else if (off == pio_ofs_status(n_out, n_in))  return REG_STATUS;
    else if (off == pio_ofs_mask(n_out, n_in))    return REG_MASK;
    else                                          return REG_NONE;
  endfunction

endpackage

// File: rtl/mmio_parallel_port_if.sv
// Core data-bus slice seen by the parallel port: store path, load path and
// the DataMem read data that is passed through outside the window.
interface mmio_parallel_port_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);

  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rdata;
  logic              hit;

  modport master (
    output we, addr, wdata, mem_rdata,
    input  rdata, hit
  );

  modport slave (
    input  we, addr, wdata, mem_rdata,
    output rdata, hit
  );

endinterface

// File: rtl/in_sync_edge.sv
// One input channel: two-flop synchroniser, previous-value register and a
// combinational change indication (s2 differs from the value one edge earlier).
module in_sync_edge #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_async,
  output logic [DATA_W-1:0] o_sync,
  output logic              o_changed
);

  logic [DATA_W-1:0] r_s1;
  logic [DATA_W-1:0] r_s2;
  logic [DATA_W-1:0] r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign o_sync    = r_s2;
  assign o_changed = (r_s2 != r_prev);

endmodule

// File: rtl/mmio_parallel_port.sv
// Memory-mapped multi-channel parallel I/O port: output registers with write
// strobes, synchronised inputs with W1C change flags, interrupt mask and irq.
module mmio_parallel_port
  import mmio_parallel_port_pkg::*;
#(
  parameter int DATA_W    = PIO_DATA_W,
  parameter int ADDR_W    = PIO_ADDR_W,
  parameter int N_OUT     = PIO_N_OUT,
  parameter int N_IN      = PIO_N_IN,
  parameter int BASE_ADDR = PIO_BASE_ADDR
) (
  input  logic                    clk,
  input  logic                    rst,
  mmio_parallel_port_if.slave     bus,
  input  logic [N_IN*DATA_W-1:0]  data_in,
  output logic [N_OUT*DATA_W-1:0] data_out,
  output logic [N_OUT-1:0]        out_strobe,
  output logic                    irq
);

  localparam int WIN        = pio_win_size(N_OUT, N_IN);
  localparam int OFS_OUT0   = pio_ofs_out0();
  localparam int OFS_IN0    = pio_ofs_in0(N_OUT);

  localparam logic [ADDR_W-1:0] BASE_L = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_L = ADDR_W'(BASE_ADDR + WIN - 1);

  if (N_IN < 1 || N_IN > DATA_W) begin : g_bad_n_in
    $error("mmio_parallel_port: N_IN must be in 1..DATA_W");
  end
  if (N_OUT < 1 || N_OUT > 8) begin : g_bad_n_out
    $error("mmio_parallel_port: N_OUT must be in 1..8");
  end
  if (BASE_ADDR + WIN - 1 > (1 << ADDR_W) - 1) begin : g_bad_window
    $error("mmio_parallel_port: register window wraps past the top of the address space");
  end

  logic              w_hit;
  logic              w_wr;
  logic [ADDR_W-1:0] w_offset;
  reg_kind_e         w_kind;
  logic [N_OUT-1:0]  w_out_wr;
  logic              w_status_wr;
  logic              w_mask_wr;
  logic [DATA_W-1:0] w_rdata;

  assign w_hit    = (bus.addr >= BASE_L) && (bus.addr <= LAST_L);
  assign w_offset = bus.addr - BASE_L;
  assign w_kind   = w_hit ? pio_decode(int'(w_offset), N_OUT, N_IN) : REG_NONE;
  assign w_wr     = bus.we && w_hit;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_out_wr = '0;
    for (int i = 0; i < N_OUT; i++) begin
      w_out_wr[i] = w_wr && (w_kind == REG_OUT) && (w_offset == ADDR_W'(OFS_OUT0 + i));
    end
  end

  assign w_status_wr = w_wr && (w_kind == REG_STATUS);
  assign w_mask_wr   = w_wr && (w_kind == REG_MASK);

  logic [DATA_W-1:0] w_out_q [N_OUT];

  for (genvar i = 0; i < N_OUT; i++) begin : g_out
    logic [DATA_W-1:0] r_data;
    logic              r_stb;

    // NOTE: state is updated with non-blocking assignments and cleared by the async reset, including mid-write.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_data <= '0;
        r_stb  <= 1'b0;
      end else begin
        r_stb <= w_out_wr[i];
        if (w_out_wr[i]) r_data <= bus.wdata;
      end
    end

    assign w_out_q[i]                    = r_data;
    assign data_out[i*DATA_W +: DATA_W]  = r_data;
    assign out_strobe[i]                 = r_stb;
  end

  logic [DATA_W-1:0] w_in_q [N_IN];
  logic [N_IN-1:0]   w_changed;

  for (genvar j = 0; j < N_IN; j++) begin : g_in
    in_sync_edge #(
      .DATA_W (DATA_W)
    ) u_sync (
      .clk       (clk),
      .rst       (rst),
      .i_async   (data_in[j*DATA_W +: DATA_W]),
      .o_sync    (w_in_q[j]),
      .o_changed (w_changed[j])
    );
  end

  logic [N_IN-1:0] r_status;
  logic [N_IN-1:0] r_mask;
  logic [N_IN-1:0] w_clr;

  assign w_clr = w_status_wr ? bus.wdata[N_IN-1:0] : '0;

  // A change detected on the same edge as a W1C of that bit keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_status <= '0;
      r_mask   <= '0;
    end else begin
      r_status <= (r_status & ~w_clr) | w_changed;
      if (w_mask_wr) r_mask <= bus.wdata[N_IN-1:0];
    end
  end

  assign irq = |(r_status & r_mask);

  always_comb begin
    w_rdata = bus.mem_rdata;
    case (w_kind)
      REG_OUT: begin
        for (int i = 0; i < N_OUT; i++) begin
          if (w_offset == ADDR_W'(OFS_OUT0 + i)) w_rdata = w_out_q[i];
        end
      end
      REG_IN: begin
        for (int j = 0; j < N_IN; j++) begin
          if (w_offset == ADDR_W'(OFS_IN0 + j)) w_rdata = w_in_q[j];
        end
      end
      REG_STATUS: w_rdata = DATA_W'(r_status);
      REG_MASK:   w_rdata = DATA_W'(r_mask);
      default:    w_rdata = bus.mem_rdata;
    endcase
  end

  assign bus.rdata = w_rdata;
  assign bus.hit   = w_hit;

endmodule

// File: tb/tb_mmio_parallel_port.sv
// Self-checking bench for mmio_parallel_port: directed register-map scenarios
// followed by randomized bus/input traffic against a behavioural model.
`timescale 1ns/1ps
module tb_mmio_parallel_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [3:0]  out_strobe;
  logic        irq;

  mmio_parallel_port_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  mmio_parallel_port #(
    .DATA_W    (8),
    .ADDR_W    (8),
    .N_OUT     (4),
    .N_IN      (4),
    .BASE_ADDR ('hF0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .data_in    (data_in),
    .data_out   (data_out),
    .out_strobe (out_strobe),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: OUT values, last-write strobes, flags, mask, and the input as seen
  // 1/2/3 edges ago. IN[j] shows the input delayed by two edges; its flag rises
  // one edge after that visible value changes.
  logic [7:0] m_out [4];
  logic [3:0] m_stb, m_status, m_mask;
  logic [7:0] d1 [4];
  logic [7:0] d2 [4];
  logic [7:0] d3 [4];
  logic [7:0] last_mem;
  logic [31:0] cur_din;

  function automatic logic in_window(input logic [7:0] a);
    return (a >= 8'hF0) && (a <= 8'hF9);
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a, input logic [7:0] memv);
    int off;
    if (!in_window(a)) return memv;
    off = int'(a) - 'hF0;
    if (off < 4)       return m_out[off];
    else if (off < 8)  return d2[off-4];
    else if (off == 8) return {4'b0, m_status};
    else               return {4'b0, m_mask};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_out[i] = '0; d1[i] = '0; d2[i] = '0; d3[i] = '0;
    end
    m_stb = '0; m_status = '0; m_mask = '0;
  endtask

  task automatic model_edge(input logic we, input logic [7:0] a, input logic [7:0] wd,
                            input logic [31:0] din);
    logic [3:0] clr, chg, stb;
    int off;
    clr = '0; chg = '0; stb = '0;
    for (int j = 0; j < 4; j++) chg[j] = (d2[j] != d3[j]);
    if (we && in_window(a)) begin
      off = int'(a) - 'hF0;
      if (off < 4) begin
        m_out[off] = wd;
        stb[off]   = 1'b1;
      end else if (off == 8) begin
        clr = wd[3:0];
      end else if (off == 9) begin
        m_mask = wd[3:0];
      end
    end
    m_status = (m_status & ~clr) | chg;
    m_stb    = stb;
    for (int j = 0; j < 4; j++) begin
      d3[j] = d2[j];
      d2[j] = d1[j];
      d1[j] = din[j*8 +: 8];
    end
  endtask

  task automatic compare_outputs(input logic [7:0] a);
    check("rdata", bus.rdata, model_read(a, last_mem));
    check("hit", bus.hit, in_window(a));
    check("irq", irq, |(m_status & m_mask));
    check("data_out", data_out, {m_out[3], m_out[2], m_out[1], m_out[0]});
    check("strobe", out_strobe, m_stb);
  endtask

  // One bus cycle: drive at negedge, check combinational view, advance the model
  // at the rising edge, return 1ns after that edge.
  task automatic cycle(input logic we, input logic [7:0] a, input logic [7:0] wd);
    @(negedge clk);
    last_mem      = 8'($urandom);
    bus.we        = we;
    bus.addr      = a;
    bus.wdata     = wd;
    bus.mem_rdata = last_mem;
    data_in       = cur_din;
    #1;
    compare_outputs(a);
    @(posedge clk);
    model_edge(we, a, wd, cur_din);
    #1;
  endtask

  task automatic peek(input string tag, input logic [7:0] a, input logic [7:0] exp,
                      input logic exp_hit);
    bus.we   = 1'b0;
    bus.addr = a;
    #1;
    check({tag, "_rd"}, bus.rdata, exp);
    check({tag, "_hit"}, bus.hit, exp_hit);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    check("rst_data_out", data_out, 32'h0);
    check("rst_strobe", out_strobe, 4'h0);
    check("rst_irq", irq, 1'b0);
    model_reset();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.mem_rdata = '0;
    data_in = '0; cur_din = '0; last_mem = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_data_out", data_out, 32'h0);
    check("init_strobe", out_strobe, 4'h0);
    check("init_irq", irq, 1'b0);
    #1;
    rst = 1'b1;

    // Flag from a steady nonzero input, unmasked, so irq is high before reset.
    cur_din = 32'h0000_0001;
    cycle(1'b1, 8'hF9, 8'h01);
    cycle(1'b0, 8'hF8, 8'h00);
    cycle(1'b0, 8'hF8, 8'h00);
    peek("pre_status", 8'hF8, 8'h01, 1'b1);
    check("pre_irq", irq, 1'b1);

    // 1: writes then an asynchronous reset pulse between edges.
    cycle(1'b1, 8'hF0, 8'h11);
    cycle(1'b1, 8'hF3, 8'hFF);
    check("t1_strobe_pre", out_strobe, 4'b1000);
    pulse_reset();
    peek("t1_f3", 8'hF3, 8'h00, 1'b1);

    // 2: single OUT write, strobe for one cycle, miss passes DataMem through.
    cycle(1'b1, 8'hF2, 8'hA5);
    check("t2_strobe", out_strobe, 4'b0100);
    check("t2_data_out", data_out, 32'h00A5_0000);
    cycle(1'b0, 8'h10, 8'h00);
    check("t2_strobe_off", out_strobe, 4'b0000);
    peek("t2_miss", 8'h10, last_mem, 1'b0);
    cycle(1'b0, 8'hF8, 8'h00);
    cycle(1'b0, 8'hF8, 8'h00);
    cycle(1'b1, 8'hF8, 8'h0F);
    peek("t2_clr", 8'hF8, 8'h00, 1'b1);

    // 3: ch1 00->3C, visible after 2 edges, flagged after 3.
    cur_din = 32'h0000_3C01;
    cycle(1'b0, 8'hF5, 8'h00);
    peek("t3_f5_e1", 8'hF5, 8'h00, 1'b1);
    cycle(1'b0, 8'hF5, 8'h00);
    peek("t3_f5_e2", 8'hF5, 8'h3C, 1'b1);
    peek("t3_st_e2", 8'hF8, 8'h00, 1'b1);
    cycle(1'b0, 8'hF8, 8'h00);
    peek("t3_st_e3", 8'hF8, 8'h02, 1'b1);
    cycle(1'b0, 8'hF8, 8'h00);
    cycle(1'b0, 8'hF8, 8'h00);
    peek("t3_st_hold", 8'hF8, 8'h02, 1'b1);

    // 4: mask, irq, W1C of the wrong bit, then the right bit.
    cycle(1'b1, 8'hF9, 8'h02);
    check("t4_irq_on", irq, 1'b1);
    cycle(1'b1, 8'hF8, 8'h01);
    peek("t4_st_keep", 8'hF8, 8'h02, 1'b1);
    cycle(1'b1, 8'hF8, 8'h02);
    peek("t4_st_clr", 8'hF8, 8'h00, 1'b1);
    check("t4_irq_off", irq, 1'b0);

    // 5: detection edge coincides with W1C of the same bit.
    cur_din = 32'h0000_5501;
    cycle(1'b0, 8'hF8, 8'h00);
    cycle(1'b0, 8'hF8, 8'h00);
    cycle(1'b1, 8'hF8, 8'h02);
    peek("t5_set_wins", 8'hF8, 8'h02, 1'b1);
    check("t5_irq", irq, 1'b1);

    // 6: write to an IN offset is ignored; write past the window is a miss.
    cycle(1'b1, 8'hF5, 8'h77);
    check("t6_no_strobe", out_strobe, 4'b0000);
    peek("t6_f5", 8'hF5, 8'h55, 1'b1);
    cycle(1'b1, 8'hFA, 8'h33);
    check("t6_fa_strobe", out_strobe, 4'b0000);
    peek("t6_fa", 8'hFA, last_mem, 1'b0);

    // Randomized traffic around and inside the window.
    for (int n = 0; n < 400; n++) begin
      logic       we;
      logic [7:0] a;
      if ($urandom_range(0, 7) == 0) begin
        int ch;
        ch = int'($urandom_range(0, 3));
        cur_din[ch*8 +: 8] = 8'($urandom);
      end
      we = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range('hEC, 'hFD));
      if ($urandom_range(0, 15) == 0) a = 8'($urandom);
      cycle(we, a, 8'($urandom));
      if (n == 200) pulse_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
